// File: rtl/ex_alu_unit.sv
// Execute-stage RV32I ALU with valid/ready handshakes and a one-entry result register.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; default build shifts serially 1 bit/cycle.
module ex_alu_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LINK_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluLink = 4'b1111;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic            accept;

  assign shamt = op_b[4:0];

  // Single-cycle datapath; in the serial build shift codes fall to default and are
  // loaded as op_a instead.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOr:   alu_res = op_a | op_b;
      AluXor:  alu_res = op_a ^ op_b;
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      AluSltu: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      AluLink: alu_res = op_a + XLEN'(LINK_INC);
`ifdef ALU_BARREL_SHIFT_EN
      AluSll:  alu_res = op_a << shamt;
      AluSrl:  alu_res = op_a >> shamt;
      AluSra:  alu_res = $signed(op_a) >>> shamt;
`endif
      default: alu_res = '0;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] shift_step;
  logic            is_shift;

  assign is_shift = (alu_ctrl == AluSll) || (alu_ctrl == AluSrl) || (alu_ctrl == AluSra);

  always_comb begin
    shift_step = result_q;
    case (ctrl_q)
      AluSll:  shift_step = {result_q[XLEN-2:0], 1'b0};
      AluSrl:  shift_step = {1'b0, result_q[XLEN-1:1]};
      default: shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end
`endif

  assign in_ready  = !rst && !flush &&
                     ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);
  assign result    = result_q;
  assign zero      = (result_q == '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_BARREL_SHIFT_EN
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
`endif
    unique case (state_q)
`ifndef ALU_BARREL_SHIFT_EN
      StShift: begin
        result_d = shift_step;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StHold;
        end
      end
`endif
      StIdle, StHold: begin
        if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift) begin
            result_d = op_a;
            ctrl_d   = alu_ctrl;
            cnt_d    = shamt;
            state_d  = (shamt == 5'd0) ? StHold : StShift;
          end else begin
            result_d = alu_res;
            state_d  = StHold;
          end
`else
          result_d = alu_res;
          state_d  = StHold;
`endif
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush drops whatever is in flight; the stale result is hidden by out_valid=0.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
`ifndef ALU_BARREL_SHIFT_EN
      cnt_q    <= '0;
      ctrl_q   <= AluAdd;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifndef ALU_BARREL_SHIFT_EN
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed corner cases plus random ops against
// an arithmetic reference model.
module tb_ex_alu_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  ex_alu_unit #(
    .XLEN     (32),
    .LINK_INC (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned s;
    logic [31:0] pow;
    int signed   ia;
    int signed   ib;
    s   = b % 32;
    pow = 32'd1 << s;
    ia  = a;
    ib  = b;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a * pow;
      4'd6:    return a / pow;
      4'd7:    return (ia < ib) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return ia >>> s;
      4'd15:   return a + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (c == 4'd5 || c == 4'd6 || c == 4'd9) return (b % 32) + 1;
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1 and check latency, busy in_ready, result and zero.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int lat;
    int n;
    int rdy_seen;
    exp = model(c, a, b);
    lat = exp_lat(c, b);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n        = 1;
    rdy_seen = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy in_ready"}, 32'(rdy_seen), 32'd0);
    check({tag, " result"}, result, exp);
    check({tag, " zero"}, 32'(zero), (exp == 32'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [3:0]  codes [13];
    logic [31:0] ba [10];
    logic [31:0] bb [10];
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;

    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
              4'd10, 4'd13, 4'd15};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 4'd0; op_a = '0; op_b = '0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    check("rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Directed ops
    run_op(4'd0, 32'd7, 32'hFFFF_FFF9, "add 7-7");
    run_op(4'd1, 32'd5, 32'd9, "sub 5-9");
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(4'd15, 32'h100, 32'h0, "link");
    run_op(4'd9, 32'h8000_0000, 32'd31, "sra 31");
    run_op(4'd5, 32'h1234_5678, 32'hFFFF_FFE0, "sll shamt0");
    run_op(4'd12, 32'hDEAD_BEEF, 32'h1, "reserved");

    // Stall in HOLD, then 10 back-to-back ANDs
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'd3;
    op_a      = 32'h0F0;
    op_b      = 32'h00F;
    @(negedge clk);
    in_valid = 1'b0;
    held     = result;
    check("stall first result", result, 32'h0FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall result stable", result, held);
    end
    for (int i = 0; i < 10; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 4'd2;
    op_a      = ba[0];
    op_b      = bb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b2b out_valid", 32'(out_valid), 32'd1);
      check("b2b result", result, ba[i] & bb[i]);
      if (i < 9) begin
        op_a = ba[i + 1];
        op_b = bb[i + 1];
      end else begin
        in_valid = 1'b0;
      end
    end

    // Flush on cycle 5 of sll by 20; op presented during flush must be dropped
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'd5;
    op_a     = 32'h1;
    op_b     = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'd0;
    op_a     = 32'd1;
    op_b     = 32'd2;
    check("flush in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    seen     = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("flush no out_valid", 32'(seen), 32'd0);
    run_op(4'd0, 32'd40, 32'd2, "post-flush add");

    // Reset mid-shift
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'd9;
    op_a     = 32'hF000_0000;
    op_b     = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("midrst no out_valid", 32'(seen), 32'd0);

    // Random ops
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(codes[$urandom_range(0, 12)], ra, rb, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
